// File: rtl/apb_i2c_master_arb_if.sv
// Requester-side and APB-side signal bundle for the two-requester APB master sequencer.
// The arbiter connects through the master modport; the requesters and the APB slave use the slave modport.
interface apb_i2c_master_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          REQ;
  logic [1:0]          REQ_WRITE;
  logic [2*ADDR_W-1:0] REQ_ADDR;
  logic [2*DATA_W-1:0] REQ_WDATA;
  logic [1:0]          ACK;
  logic [DATA_W-1:0]   RSP_RDATA;
  logic                RSP_ERR;
  logic                BUSY;
  logic                PSELx;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    output ACK, RSP_RDATA, RSP_ERR, BUSY, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    input  ACK, RSP_RDATA, RSP_ERR, BUSY, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_i2c_master_arb.sv
// Round-robin APB master sharing one I2C APB slave between two requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles without PREADY.
module apb_i2c_master_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_i2c_master_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [1:0] req;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign req[i] = {bus.REQ_WRITE[i], bus.REQ_ADDR[i*ADDR_W +: ADDR_W], bus.REQ_WDATA[i*DATA_W +: DATA_W]};
  end

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              gnt;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    gnt          = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          // a lone requester wins outright; a tie goes to whoever was not served last
          gnt          = (&bus.REQ) ? ~last_grant_q : bus.REQ[1];
          grant_d      = gnt;
          last_grant_d = gnt;
          pwrite_d     = req[gnt].write;
          paddr_d      = req[gnt].addr;
          pwdata_d     = req[gnt].wdata;
          psel_d       = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (bus.PREADY) begin
          err_d          = bus.PSLVERR;
          rdata_d        = pwrite_q ? '0 : bus.PRDATA;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          err_d          = 1'b1;
          rdata_d        = '0;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        ack_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.ACK       = ack_q;
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;
  assign bus.BUSY      = busy_q;

endmodule
